unsigned_seq_div_restoring: RTL and testbench

- Sequential unsigned restoring divider; the inverse of the shift-add sequential multiplier in the arithmetic library.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock, using shift-left and trial subtract.
- Operands are captured on a load handshake. Results are registered and held until the next accepted load.
- Used by datapath blocks that need area-cheap division and can tolerate a multi-cycle latency.

---
 rtl/unsigned_seq_div_restoring.sv | 144 ++++++++++++++
 tb/tb_unsigned_seq_div_restoring.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unsigned_seq_div_restoring.sv
// rtl/unsigned_seq_div_restoring.sv - sequential unsigned restoring divider, one quotient bit per clock
module unsigned_seq_div_restoring #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero
);

   // iteration counter only has to reach WIDTH-1
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;

   // partial remainder A: after every restore it is below M, so its top
   // bit is always zero between iterations and only the trial needs WIDTH+1 bits
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_m;
   logic [CW-1:0]    r_count;

   logic [WIDTH-1:0] r_quotient;
   logic [WIDTH-1:0] r_remainder;
   logic             r_done;
   logic             r_div_by_zero;

   logic             w_start;
   logic             w_iter;
   logic             w_fin;
   logic             w_last;
   logic             w_dz;
   logic [WIDTH:0]   w_a_sh;
   logic [WIDTH:0]   w_trial;

   assign w_last  = (r_count == CW'(WIDTH - 1));
   assign w_dz    = (r_m == '0);
   assign w_a_sh  = {r_a, r_q[WIDTH-1]};
   assign w_trial = w_a_sh - {1'b0, r_m};

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // next-state: a zero divisor skips the iterations entirely
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (load) begin
               w_next = (divisor == '0) ? S_FIN : S_RUN;
            end
         end
         S_RUN: begin
            if (w_last) begin
               w_next = S_FIN;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state decode used by datapath and result registers
   always_comb begin
      w_start = 1'b0;
      w_iter  = 1'b0;
      w_fin   = 1'b0;
      busy    = 1'b0;
      case (r_state)
         S_IDLE: w_start = load;
         S_RUN: begin
            w_iter = 1'b1;
            busy   = 1'b1;
         end
         S_FIN: begin
            w_fin = 1'b1;
            busy  = 1'b1;
         end
         default: ;
      endcase
   end

   // operand capture and shift / trial-subtract iteration
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_a     <= '0;
         r_q     <= '0;
         r_m     <= '0;
         r_count <= '0;
      end else if (w_start) begin
         r_a     <= '0;
         r_q     <= dividend;
         r_m     <= divisor;
         r_count <= '0;
      end else if (w_iter) begin
         // negative trial result means restore the shifted A
         r_a     <= w_trial[WIDTH] ? w_a_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
         r_q     <= {r_q[WIDTH-2:0], ~w_trial[WIDTH]};
         r_count <= r_count + 1'b1;
      end
   end

   // result registers update only in FIN; Q still holds the dividend on divide by zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_quotient    <= '0;
         r_remainder   <= '0;
         r_div_by_zero <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_done <= w_fin;
         if (w_fin) begin
            r_quotient    <= w_dz ? {WIDTH{1'b1}} : r_q;
            r_remainder   <= w_dz ? r_q : r_a;
            r_div_by_zero <= w_dz;
         end
      end
   end

   assign quotient    = r_quotient;
   assign remainder   = r_remainder;
   assign done        = r_done;
   assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_unsigned_seq_div_restoring.sv
// tb/tb_unsigned_seq_div_restoring.sv - scoreboard testbench for unsigned_seq_div_restoring
module tb_unsigned_seq_div_restoring;

   localparam int W = 6;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dz;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   checks = 0;
   int   errors = 0;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] dividend = '0;
   logic [W-1:0] divisor = '0;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         busy;
   logic         done;
   logic         div_by_zero;

   unsigned_seq_div_restoring #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   // reference result pushed when stimulus is driven
   task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      e.a = a;
      e.b = b;
      if (b == '0) begin
         e.q  = {W{1'b1}};
         e.r  = a;
         e.dz = 1'b1;
      end else begin
         e.q  = W'(int'(a) / int'(b));
         e.r  = W'(int'(a) % int'(b));
         e.dz = 1'b0;
      end
      sb.push_back(e);
   endtask

   // scoreboard: pop and compare on every done pulse
   always @(negedge clk) begin
      if (rst && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done q=%0d r=%0d dz=%0d", quotient, remainder, div_by_zero);
         end else begin
            m_e = sb.pop_front();
            checks++;
            if (quotient !== m_e.q) begin
               errors++;
               $display("FAIL quotient %0d/%0d got %0d exp %0d", m_e.a, m_e.b, quotient, m_e.q);
            end
            checks++;
            if (remainder !== m_e.r) begin
               errors++;
               $display("FAIL remainder %0d/%0d got %0d exp %0d", m_e.a, m_e.b, remainder, m_e.r);
            end
            checks++;
            if (div_by_zero !== m_e.dz) begin
               errors++;
               $display("FAIL div_by_zero %0d/%0d got %0d exp %0d", m_e.a, m_e.b, div_by_zero, m_e.dz);
            end
            if (!m_e.dz) begin
               checks++;
               if (int'(quotient) * int'(m_e.b) + int'(remainder) != int'(m_e.a)) begin
                  errors++;
                  $display("FAIL invariant_sum %0d/%0d got q=%0d r=%0d", m_e.a, m_e.b, quotient, remainder);
               end
               checks++;
               if (!(remainder < m_e.b)) begin
                  errors++;
                  $display("FAIL invariant_rem %0d/%0d got r=%0d exp below %0d", m_e.a, m_e.b, remainder, m_e.b);
               end
            end
         end
      end
   end

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout busy=%0d exp 0", busy);
      end
   endtask

   // called at the negedge following the accepting edge
   task automatic wait_done(output int edges, output int nb);
      edges = 0;
      nb    = busy ? 1 : 0;
      while (!done && edges < 64) begin
         @(posedge clk);
         @(negedge clk);
         edges++;
         if (busy) nb++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout done=%0d exp 1", done);
      end
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
      int edges;
      int nb;
      int exp_lat;
      exp_lat = (b == '0) ? 1 : W + 1;
      wait_idle();
      dividend = a;
      divisor  = b;
      load     = 1'b1;
      push_exp(a, b);
      @(posedge clk);
      @(negedge clk);
      load     = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      wait_done(edges, nb);
      checks++;
      if (edges != exp_lat) begin
         errors++;
         $display("FAIL latency %0d/%0d got %0d exp %0d", a, b, edges, exp_lat);
      end
      checks++;
      if (nb != exp_lat) begin
         errors++;
         $display("FAIL busy_cycles %0d/%0d got %0d exp %0d", a, b, nb, exp_lat);
      end
   endtask

   task automatic check_cleared(input string tag);
      checks++;
      if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         errors++;
         $display("FAIL %s got q=%0d r=%0d busy=%0d done=%0d dz=%0d exp all 0",
                  tag, quotient, remainder, busy, done, div_by_zero);
      end
   endtask

   task automatic test_reset();
      #12;
      check_cleared("reset_state");
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      run_op(6'd45, 6'd6);
   endtask

   task automatic test_boundaries();
      run_op(6'd63, 6'd1);
      run_op(6'd5, 6'd9);
      run_op(6'd0, 6'd13);
      run_op(6'd63, 6'd63);
      run_op(6'd62, 6'd63);
   endtask

   task automatic test_div_zero();
      run_op(6'd17, 6'd0);
      run_op(6'd20, 6'd4);
   endtask

   task automatic test_back_to_back();
      int edges;
      int nb;
      int n;
      wait_idle();
      dividend = 6'd45;
      divisor  = 6'd6;
      load     = 1'b1;
      push_exp(6'd45, 6'd6);
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      @(negedge clk);
      // load while busy must be ignored
      dividend = 6'd60;
      divisor  = 6'd5;
      load     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      n = 0;
      while (!done && n < 64) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL b2b_first_done done=%0d exp 1", done);
      end
      // load held during the done cycle is accepted
      dividend = 6'd60;
      divisor  = 6'd5;
      load     = 1'b1;
      push_exp(6'd60, 6'd5);
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      wait_done(edges, nb);
      checks++;
      if (edges + 1 != W + 2) begin
         errors++;
         $display("FAIL b2b_spacing got %0d exp %0d", edges + 1, W + 2);
      end
   endtask

   task automatic test_reset_abort();
      wait_idle();
      dividend = 6'd45;
      divisor  = 6'd6;
      load     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      load = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check_cleared("reset_abort");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet got done=%0d busy=%0d exp 0 0", done, busy);
         end
      end
      run_op(6'd45, 6'd6);
   endtask

   task automatic test_random();
      logic [W-1:0] a;
      logic [W-1:0] b;
      for (int i = 0; i < 500; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(0, 7) == 0) b = '0;
         run_op(a, b);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_boundaries();
      test_div_zero();
      test_back_to_back();
      test_reset_abort();
      test_random();
      repeat (4) @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
